fifo_stream_reader: RTL and testbench

Read-side drain engine for the synchronous FIFO. It issues `fifo_rd_en` against the FIFO's `empty` flag and absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer. It presents the data as a valid/ready stream to a downstream consumer. It sits between the FIFO's read port and any consumer that may apply backpressure.

---
 rtl/fifo_stream_reader_pkg.sv | 15 +
 rtl/fifo_stream_reader_if.sv | 27 ++
 rtl/fifo_stream_reader_skid_buf.sv | 64 ++++++
 rtl/fifo_stream_reader.sv | 64 ++++++
 tb/tb_fifo_stream_reader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fifo_pkg;

  localparam int SKID_DEPTH         = 2;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream, as seen by the drain engine.
// Latency: none (wiring only).
// Backpressure: m_ready from the consumer; fifo_empty from the FIFO.
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry ordered skid buffer; head entry and valid come straight from flops.
// Latency: a push is visible on head/valid the following cycle.
// Backpressure: caller must never push into a full buffer without popping.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  rd_state_e             state, state_nxt;
  logic [DATA_WIDTH-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      valid <= (state_nxt != EMPTY);
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_nxt = ONE;
        ONE:     if (push && !pop) state_nxt = FULL;
                 else if (pop && !push) state_nxt = EMPTY;
        FULL:    if (pop && !push) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Head is a shift stage: on pop it takes the tail, so m_data never comes through a mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (!flush) begin
      if (pop && state == FULL) head <= tail;
      if (push) begin
        if (state == EMPTY || (state == ONE && pop)) head <= push_data;
        else                                        tail <= push_data;
      end
    end
  end

  assign occ = state;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream through a 2-entry skid buffer; optional counters under FIFO_READER_STATS_EN.
// Latency: fifo_rd_en in cycle N gives m_valid in cycle N+2; 1 word/cycle sustained.
// Backpressure: m_ready low throttles fifo_rd_en so buffered plus in-flight words never exceed 2.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  fifo_stream_reader_if.master bus,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  logic       inflight;
  logic       pop;
  logic [1:0] occ;
  logic [2:0] level;

  assign pop   = bus.m_valid && bus.m_ready;
  assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

  // Gated by rst_n so the request drops the instant reset is applied, not at the next edge.
  assign bus.fifo_rd_en = rst_n && !bus.fifo_empty && !flush && (level < 3'(SKID_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= bus.fifo_rd_en;
  end

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (inflight && !flush),
    .push_data (bus.fifo_dout),
    .pop       (pop),
    .valid     (bus.m_valid),
    .head      (bus.m_data),
    .occ       (occ)
  );

`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count    <= '0;
      stall_count <= '0;
    end else begin
      if (pop && rd_count != '1) rd_count <= rd_count + 1'b1;
      if (bus.m_ready && !bus.m_valid && bus.fifo_empty && stall_count != '1)
        stall_count <= stall_count + 1'b1;
    end
  end
`else
  assign rd_count    = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural registered-read FIFO on the read port.
module tb_fifo_stream_reader;

`ifdef FIFO_READER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] rd_count;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus ();

  fifo_stream_reader #(
    .DATA_WIDTH (8),
    .CNT_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .rd_count    (rd_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: one-cycle registered read, never reset.
  logic [7:0] fifo_mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         bad_rd = 0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      if (wr_ptr == rd_ptr) begin
        bad_rd <= bad_rd + 1;
      end else begin
        bus.fifo_dout <= fifo_mem[rd_ptr];
        rd_ptr        <= rd_ptr + 1;
      end
    end
  end

  task automatic push_word(input logic [7:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  logic [7:0] got [$];

  // Call just after a negedge with inputs set; samples accepted words for a fixed cycle budget.
  task automatic collect(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      #1;
      if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
      @(negedge clk);
    end
  endtask

  task automatic check_got(input string name, input logic [7:0] exp [$]);
    check({name, "_count"}, 0, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) check(name, i, got[i], exp[i]);
      else                check(name, i, 32'hFFFF_FFFF, exp[i]);
    end
  endtask

  typedef struct {
    logic       push;
    logic [7:0] pdat;
    logic       rdy;
    logic       exp_rd;
    logic       exp_vld;
    logic [7:0] exp_dat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int         pulses;
    logic [7:0] exp_q [$];

    vecs[0] = '{1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hA1};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB2};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC3};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

    bus.m_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_rd_en", 0, bus.fifo_rd_en, 0);
    check("rst_valid", 0, bus.m_valid, 0);
    check("rst_data", 0, bus.m_data, 0);
    check("rst_rd_count", 0, rd_count, 0);
    check("rst_stall_count", 0, stall_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Three words, consumer always ready.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vecs[i].push) push_word(vecs[i].pdat);
      bus.m_ready = vecs[i].rdy;
      #1;
      check("s1_rd_en", i, bus.fifo_rd_en, vecs[i].exp_rd);
      check("s1_valid", i, bus.m_valid, vecs[i].exp_vld);
      if (vecs[i].exp_vld) check("s1_data", i, bus.m_data, vecs[i].exp_dat);
    end
    @(negedge clk);
    bus.m_ready = 1'b0;
    #1;
    check("s1_rd_count", 0, rd_count, STATS ? 3 : 0);
    check("s1_stall_count", 0, stall_count, STATS ? 1 : 0);

    // Four words under backpressure: two reads, then hold.
    @(negedge clk);
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.fifo_rd_en) pulses++;
      if (i >= 2) begin
        check("bp_valid", i, bus.m_valid, 1);
        check("bp_data", i, bus.m_data, 8'h11);
      end
      @(negedge clk);
    end
    check("bp_rd_pulses", 0, pulses, 2);
    bus.m_ready = 1'b1;
    got.delete();
    collect(10);
    bus.m_ready = 1'b0;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_got("bp_order", exp_q);
    #1;
    check("bp_rd_count", 0, rd_count, STATS ? 7 : 0);

    // Empty FIFO, ready consumer: stalls only.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("idle_rd_en", i, bus.fifo_rd_en, 0);
      check("idle_valid", i, bus.m_valid, 0);
      @(negedge clk);
    end
    bus.m_ready = 1'b0;
    #1;
    check("idle_stall_count", 0, stall_count, STATS ? 5 : 0);

    // Flush with a read in flight, then flush with the buffer full.
    @(negedge clk);
    push_word(8'h51); push_word(8'h52); push_word(8'h53);
    push_word(8'h54); push_word(8'h55); push_word(8'h56);
    #1;
    check("fl_rd_en_c0", 0, bus.fifo_rd_en, 1);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl_rd_en_during", 0, bus.fifo_rd_en, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fl_valid_after", 0, bus.m_valid, 0);
    check("fl_rd_en_after", 0, bus.fifo_rd_en, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl_full_valid", 0, bus.m_valid, 1);
    check("fl_full_data", 0, bus.m_data, 8'h53);
    check("fl_full_rd_en", 0, bus.fifo_rd_en, 0);
    @(negedge clk);
    flush = 1'b0;
    bus.m_ready = 1'b1;
    #1;
    check("fl_full_valid_after", 0, bus.m_valid, 0);
    got.delete();
    collect(10);
    exp_q = '{8'h55, 8'h56};
    check_got("fl_rest", exp_q);

    // Reset mid-stream, off the clock edge.
    got.delete();
    push_word(8'h61); push_word(8'h62); push_word(8'h63); push_word(8'h64);
    push_word(8'h65); push_word(8'h66); push_word(8'h67); push_word(8'h68);
    collect(4);
    exp_q = '{8'h61, 8'h62};
    check_got("rs_before", exp_q);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rs_rd_en", 0, bus.fifo_rd_en, 0);
    check("rs_valid", 0, bus.m_valid, 0);
    check("rs_data", 0, bus.m_data, 0);
    check("rs_rd_count", 0, rd_count, 0);
    check("rs_stall_count", 0, stall_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    collect(10);
    exp_q = '{8'h66, 8'h67, 8'h68};
    check_got("rs_resume", exp_q);

    check("rd_while_empty", 0, bad_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
